// File: rtl/outer1bits_pipe.sv
// Two-stage pipelined outer-ones detector: finds the MSB-most and LSB-most set bits of a word.
// Optional OUTER1BITS_POPCNT_EN adds a registered population count output (popcnt_o).
module outer1bits_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             data_val_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             data_ready_o,
    output logic             data_val_o,
    input  logic             data_ready_i,
    output logic [WIDTH-1:0] data_left_o,
    output logic [WIDTH-1:0] data_right_o,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
`ifdef OUTER1BITS_POPCNT_EN
    output logic [IDX_W:0]   popcnt_o,
`endif
    output logic             zero_o
);

    localparam int NSEG  = WIDTH / CHUNK;
    localparam int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
`ifdef OUTER1BITS_POPCNT_EN
    localparam int PC_W  = $clog2(CHUNK + 1);
    localparam int POP_W = IDX_W + 1;
`endif

    logic                       v1_q;
    logic                       v2_q;
    logic                       s1En;
    logic                       s2En;

    logic [NSEG-1:0]            segAny_d;
    logic [NSEG-1:0]            segAny_q;
    logic [NSEG-1:0][OFF_W-1:0] segLeft_d;
    logic [NSEG-1:0][OFF_W-1:0] segLeft_q;
    logic [NSEG-1:0][OFF_W-1:0] segRight_d;
    logic [NSEG-1:0][OFF_W-1:0] segRight_q;

    logic [WIDTH-1:0]           left_d;
    logic [WIDTH-1:0]           right_d;
    logic [IDX_W-1:0]           leftIdx_d;
    logic [IDX_W-1:0]           rightIdx_d;
    logic                       zero_d;

    logic [WIDTH-1:0]           left_q;
    logic [WIDTH-1:0]           right_q;
    logic [IDX_W-1:0]           leftIdx_q;
    logic [IDX_W-1:0]           rightIdx_q;
    logic                       zero_q;

`ifdef OUTER1BITS_POPCNT_EN
    logic [NSEG-1:0][PC_W-1:0]  segPop_d;
    logic [NSEG-1:0][PC_W-1:0]  segPop_q;
    logic [POP_W-1:0]           pop_d;
    logic [POP_W-1:0]           pop_q;
`endif

    // Bubble-collapsing flow control: a stage advances whenever the one after it can take its word.
    assign s2En         = !v2_q || data_ready_i;
    assign s1En         = !v1_q || s2En;
    assign data_ready_o = s1En;

    always_comb begin
        segAny_d   = '0;
        segLeft_d  = '0;
        segRight_d = '0;
`ifdef OUTER1BITS_POPCNT_EN
        segPop_d   = '0;
`endif
        for (int k = 0; k < NSEG; k++) begin
            segAny_d[k] = |data_i[k*CHUNK +: CHUNK];
            for (int i = 0; i < CHUNK; i++) begin
                if (data_i[k*CHUNK + i]) begin
                    segLeft_d[k] = OFF_W'(i);
                end
`ifdef OUTER1BITS_POPCNT_EN
                segPop_d[k] = segPop_d[k] + PC_W'(data_i[k*CHUNK + i]);
`endif
            end
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (data_i[k*CHUNK + i]) begin
                    segRight_d[k] = OFF_W'(i);
                end
            end
        end
    end

    // Segment data is only captured alongside a valid word so idle cycles leave it untouched.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1_q       <= 1'b0;
            segAny_q   <= '0;
            segLeft_q  <= '0;
            segRight_q <= '0;
`ifdef OUTER1BITS_POPCNT_EN
            segPop_q   <= '0;
`endif
        end else if (s1En) begin
            v1_q <= data_val_i;
            if (data_val_i) begin
                segAny_q   <= segAny_d;
                segLeft_q  <= segLeft_d;
                segRight_q <= segRight_d;
`ifdef OUTER1BITS_POPCNT_EN
                segPop_q   <= segPop_d;
`endif
            end
        end
    end

    always_comb begin
        leftIdx_d  = '0;
        rightIdx_d = '0;
        zero_d     = ~|segAny_q;
        for (int k = 0; k < NSEG; k++) begin
            if (segAny_q[k]) begin
                leftIdx_d = IDX_W'(k*CHUNK + int'(segLeft_q[k]));
            end
        end
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (segAny_q[k]) begin
                rightIdx_d = IDX_W'(k*CHUNK + int'(segRight_q[k]));
            end
        end
        left_d  = zero_d ? '0 : (ONE_W << leftIdx_d);
        right_d = zero_d ? '0 : (ONE_W << rightIdx_d);
`ifdef OUTER1BITS_POPCNT_EN
        pop_d = '0;
        for (int k = 0; k < NSEG; k++) begin
            pop_d = pop_d + POP_W'(segPop_q[k]);
        end
`endif
    end

    // Result registers keep their contents when data_val_o drops; only the valid bit clears.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v2_q       <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            leftIdx_q  <= '0;
            rightIdx_q <= '0;
            zero_q     <= 1'b0;
`ifdef OUTER1BITS_POPCNT_EN
            pop_q      <= '0;
`endif
        end else if (s2En) begin
            v2_q <= v1_q;
            if (v1_q) begin
                left_q     <= left_d;
                right_q    <= right_d;
                leftIdx_q  <= leftIdx_d;
                rightIdx_q <= rightIdx_d;
                zero_q     <= zero_d;
`ifdef OUTER1BITS_POPCNT_EN
                pop_q      <= pop_d;
`endif
            end
        end
    end

    assign data_val_o   = v2_q;
    assign data_left_o  = left_q;
    assign data_right_o = right_q;
    assign left_idx_o   = leftIdx_q;
    assign right_idx_o  = rightIdx_q;
    assign zero_o       = zero_q;
`ifdef OUTER1BITS_POPCNT_EN
    assign popcnt_o     = pop_q;
`endif

endmodule

// File: tb/tb_outer1bits_pipe.sv
// Scoreboard bench for outer1bits_pipe: driver pushes model results, a monitor pops them on each consumed output.
// Define OUTER1BITS_POPCNT_EN to also exercise popcnt_o.
module tb_outer1bits_pipe;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int IDX_W = 4;

    logic             clk_i        = 1'b0;
    logic             rst_n_i      = 1'b0;
    logic             data_val_i   = 1'b0;
    logic [WIDTH-1:0] data_i       = '0;
    logic             data_ready_i = 1'b0;
    logic             data_ready_o;
    logic             data_val_o;
    logic [WIDTH-1:0] data_left_o;
    logic [WIDTH-1:0] data_right_o;
    logic [IDX_W-1:0] left_idx_o;
    logic [IDX_W-1:0] right_idx_o;
    logic             zero_o;
`ifdef OUTER1BITS_POPCNT_EN
    logic [IDX_W:0]   popcnt_o;
`endif

    typedef struct {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
        logic [IDX_W-1:0] lidx;
        logic [IDX_W-1:0] ridx;
        logic             zero;
        logic [IDX_W:0]   pop;
    } exp_t;

    exp_t expQ[$];
    int   checks       = 0;
    int   errors       = 0;
    int   readyMode    = 0;
    int   stallLeft    = 0;
    int   blockedCount = 0;

    outer1bits_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_val_i   (data_val_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i),
        .data_left_o  (data_left_o),
        .data_right_o (data_right_o),
        .left_idx_o   (left_idx_o),
        .right_idx_o  (right_idx_o),
`ifdef OUTER1BITS_POPCNT_EN
        .popcnt_o     (popcnt_o),
`endif
        .zero_o       (zero_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic [WIDTH-1:0] w);
        exp_t e;
        bit   found = 0;
        e.lidx = '0;
        e.ridx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                if (!found) e.ridx = IDX_W'(i);
                found  = 1;
                e.lidx = IDX_W'(i);
            end
        end
        e.zero  = (w == '0);
        e.left  = found ? (WIDTH'(1) << e.lidx) : '0;
        e.right = found ? (WIDTH'(1) << e.ridx) : '0;
        e.pop   = (IDX_W+1)'($countones(w));
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output actual=left %0h required=no output at %0t", data_left_o, $time);
            return;
        end
        e = expQ.pop_front();
        checkVal("left_mask",  data_left_o,  e.left);
        checkVal("right_mask", data_right_o, e.right);
        checkVal("left_idx",   left_idx_o,   e.lidx);
        checkVal("right_idx",  right_idx_o,  e.ridx);
        checkVal("zero",       zero_o,       e.zero);
`ifdef OUTER1BITS_POPCNT_EN
        checkVal("popcnt",     popcnt_o,     e.pop);
`endif
    endtask

    // Consumer and monitor: drives data_ready_i just after the falling edge, samples just before the rising edge.
    initial begin : monitor
        logic             prevStall = 0;
        logic [WIDTH-1:0] snapL = '0, snapR = '0;
        logic [IDX_W-1:0] snapLi = '0, snapRi = '0;
        logic             snapZ = 0;
        forever begin
            @(negedge clk_i);
            #1;
            if (stallLeft > 0) begin
                data_ready_i = 1'b0;
                stallLeft--;
            end else begin
                case (readyMode)
                    0:       data_ready_i = 1'b1;
                    1:       data_ready_i = 1'b0;
                    default: data_ready_i = 1'($urandom_range(0, 1));
                endcase
            end
            #3;
            if (!rst_n_i) begin
                prevStall = 0;
            end else begin
                if (prevStall) begin
                    checkVal("stall_valid", data_val_o,   1);
                    checkVal("stall_left",  data_left_o,  snapL);
                    checkVal("stall_right", data_right_o, snapR);
                    checkVal("stall_lidx",  left_idx_o,   snapLi);
                    checkVal("stall_ridx",  right_idx_o,  snapRi);
                    checkVal("stall_zero",  zero_o,       snapZ);
                end
                prevStall = data_val_o && !data_ready_i;
                snapL  = data_left_o;
                snapR  = data_right_o;
                snapLi = left_idx_o;
                snapRi = right_idx_o;
                snapZ  = zero_o;
                if (data_val_o && data_ready_i) checkOutput();
            end
        end
    end

    // Called at a falling edge; returns at a falling edge once the word has been accepted.
    task automatic applyStimulus(input logic [WIDTH-1:0] w);
        bit accepted = 0;
        data_i     = w;
        data_val_i = 1'b1;
        for (int n = 0; n < 64 && !accepted; n++) begin
            #4;
            if (data_ready_o) begin
                expQ.push_back(model(w));
                accepted = 1;
            end else begin
                blockedCount++;
            end
            @(negedge clk_i);
        end
        data_val_i = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=not accepted required=accepted word %0h", w);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && expQ.size() != 0; n++) @(negedge clk_i);
        checkVal("drain_pending", expQ.size(), 0);
    endtask

    function automatic logic [WIDTH-1:0] randWord();
        logic [WIDTH-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = '0;
            1:       w = WIDTH'(1) << $urandom_range(0, WIDTH-1);
            2:       w = WIDTH'($urandom);
            default: w = (WIDTH'(1) << $urandom_range(0, WIDTH-1)) | (WIDTH'(1) << $urandom_range(0, WIDTH-1));
        endcase
        return w;
    endfunction

    initial begin : stimulus
        logic [WIDTH-1:0] edgeWords[5];
        edgeWords = '{16'h8001, 16'h0100, 16'hFFFF, 16'hF0F1, 16'h0000};

        repeat (2) @(negedge clk_i);
        checkVal("reset_valid", data_val_o,   0);
        checkVal("reset_left",  data_left_o,  0);
        checkVal("reset_right", data_right_o, 0);
        checkVal("reset_lidx",  left_idx_o,   0);
        checkVal("reset_ridx",  right_idx_o,  0);
        checkVal("reset_zero",  zero_o,       0);
`ifdef OUTER1BITS_POPCNT_EN
        checkVal("reset_popcnt", popcnt_o, 0);
`endif
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        checkVal("ready_after_reset", data_ready_o, 1);

        readyMode = 0;
        for (int w = 0; w < 16; w++) applyStimulus(WIDTH'(w));
        foreach (edgeWords[i]) applyStimulus(edgeWords[i]);
        drain();

        // Backpressure: three stalled cycles mid-stream must fill both stages and block the producer.
        blockedCount = 0;
        applyStimulus(16'h1234);
        applyStimulus(16'h8000);
        stallLeft = 3;
        applyStimulus(16'h0001);
        applyStimulus(16'h0A50);
        applyStimulus(16'h7FFE);
        checkVal("backpressure_blocked", blockedCount > 0, 1);
        drain();

        // Bubble collapse: output stalled, stage 1 empty, a new word is still taken.
        readyMode = 1;
        applyStimulus(16'h0300);
        @(negedge clk_i);
        data_i     = 16'h4004;
        data_val_i = 1'b1;
        #4;
        checkVal("bubble_ready", data_ready_o, 1);
        expQ.push_back(model(16'h4004));
        @(negedge clk_i);
        data_val_i = 1'b0;
        #4;
        checkVal("full_ready", data_ready_o, 0);
        @(negedge clk_i);
        readyMode = 0;
        drain();

        // Reset with two words in flight: they are dropped and the next word is clean.
        readyMode = 1;
        applyStimulus(16'h00F0);
        applyStimulus(16'h0F00);
        @(negedge clk_i);
        #2;
        checkVal("pre_reset_valid", data_val_o, 1);
        rst_n_i = 1'b0;
        #1;
        checkVal("async_reset_valid", data_val_o,  0);
        checkVal("async_reset_left",  data_left_o, 0);
        checkVal("async_reset_zero",  zero_o,      0);
        expQ.delete();
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        readyMode = 0;
        @(negedge clk_i);
        applyStimulus(16'h0420);
        drain();

        readyMode = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
            else applyStimulus(randWord());
        end
        readyMode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
